// File: rtl/serial_pkg.sv
// Shared constants, state encoding and word decode for the 2-bit serial receive path.
package serial_pkg;

  localparam logic [7:0] COMMA_BC   = 8'hBC;
  localparam int         SYM_DIBITS = 4;
  localparam int         PHASE_W    = $clog2(SYM_DIBITS);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SYM_DIBITS - 1);
  localparam logic [8:0]         IDLE_WORD  = {1'b0, COMMA_BC};

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  // The comma is reserved, so it always decodes as idle regardless of the valid bit.
  function automatic logic [8:0] decode_word(input logic [7:0] win);
    return (win == COMMA_BC) ? IDLE_WORD : {1'b1, win};
  endfunction

endpackage

// File: rtl/serial_align_fsm.sv
// Symbol alignment FSM: hunts for a comma window, then counts aligned commas until lock.
module serial_align_fsm
  import serial_pkg::*;
#(
  parameter int unsigned BC_LOCK_COUNT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               win_is_bc,
  input  logic [PHASE_W-1:0] phase,
  output align_state_e       state,
  output logic [3:0]         bc_cnt,
  output logic               active
);

  localparam logic [3:0] LOCK_CNT = 4'(BC_LOCK_COUNT);

  align_state_e state_q, state_d;
  logic [3:0]   bc_cnt_q, bc_cnt_d;
  logic [3:0]   bc_cnt_inc;

  assign bc_cnt_inc = bc_cnt_q + 4'd1;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      bc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bc_cnt_q <= bc_cnt_d;
    end
  end

  // NOTE: defaults assigned first so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    bc_cnt_d = bc_cnt_q;
    unique case (state_q)
      ST_HUNT: begin
        if (win_is_bc) begin
          bc_cnt_d = 4'd1;
          state_d  = (LOCK_CNT == 4'd1) ? ST_LOCKED : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (phase == PHASE_LAST) begin
          if (win_is_bc) begin
            bc_cnt_d = bc_cnt_inc;
            if (bc_cnt_inc == LOCK_CNT) state_d = ST_LOCKED;
          end else begin
            bc_cnt_d = '0;
            state_d  = ST_HUNT;
          end
        end
      end
      ST_LOCKED: state_d = ST_LOCKED;
      default: begin
        state_d  = ST_HUNT;
        bc_cnt_d = '0;
      end
    endcase
  end

  assign state  = state_q;
  assign bc_cnt = bc_cnt_q;
  assign active = (state_q == ST_LOCKED);

endmodule

// File: rtl/serial_paralelo_2b.sv
// 2-bit serial to 9-bit parallel receiver: comma alignment, symbol rebuild and one-cycle word strobe.
module serial_paralelo_2b
  import serial_pkg::*;
#(
  parameter int unsigned BC_LOCK_COUNT = 4
) (
  input  logic       clk16f,
  input  logic       reset_L,
  input  logic [1:0] serial,
  output logic [8:0] paralelo,
  output logic       paralelo_valid,
  output logic       active
);

  logic [5:0]         sh_q;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [8:0]         paralelo_q, paralelo_d;
  logic               valid_q, valid_d;

  logic [7:0]   win;
  logic         win_is_bc;
  logic         boundary;
  align_state_e state;
  logic [3:0]   bc_cnt;

  assign win       = {sh_q, serial};
  assign win_is_bc = (win == COMMA_BC);

  serial_align_fsm #(
    .BC_LOCK_COUNT(BC_LOCK_COUNT)
  ) u_align (
    .clk      (clk16f),
    .rst_n    (reset_L),
    .win_is_bc(win_is_bc),
    .phase    (phase_q),
    .state    (state),
    .bc_cnt   (bc_cnt),
    .active   (active)
  );

  // bc_cnt is zero exactly while hunting; the phase restarts from the edge that finds a comma.
  assign phase_d  = (bc_cnt == 4'd0) ? '0 : phase_q + 1'b1;
  assign boundary = (state == ST_LOCKED) && (phase_q == PHASE_LAST);

  always_comb begin
    paralelo_d = paralelo_q;
    valid_d    = boundary;
    if (boundary) paralelo_d = decode_word(win);
  end

  always_ff @(posedge clk16f or negedge reset_L) begin
    if (!reset_L) begin
      sh_q       <= '0;
      phase_q    <= '0;
      paralelo_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      sh_q       <= {sh_q[3:0], serial};
      phase_q    <= phase_d;
      paralelo_q <= paralelo_d;
      valid_q    <= valid_d;
    end
  end

  assign paralelo       = paralelo_q;
  assign paralelo_valid = valid_q;

endmodule

// File: tb/tb_serial_paralelo_2b.sv
// Self-checking bench for serial_paralelo_2b: lock-count 4 and lock-count 1 builds against a symbol-level model.
module tb_serial_paralelo_2b;

  logic       clk16f  = 1'b0;
  logic       reset_L = 1'b0;
  logic [1:0] serial  = 2'b00;

  logic [8:0] par0, par1;
  logic       v0, v1, a0, a1;

  serial_paralelo_2b #(.BC_LOCK_COUNT(4)) dut (
    .clk16f        (clk16f),
    .reset_L       (reset_L),
    .serial        (serial),
    .paralelo      (par0),
    .paralelo_valid(v0),
    .active        (a0)
  );

  serial_paralelo_2b #(.BC_LOCK_COUNT(1)) dut1 (
    .clk16f        (clk16f),
    .reset_L       (reset_L),
    .serial        (serial),
    .paralelo      (par1),
    .paralelo_valid(v1),
    .active        (a1)
  );

  always #5 clk16f = ~clk16f;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- symbol-level reference model ----------------
  int         lock_need [2] = '{4, 1};
  int         m_anchor  [2];
  int         m_count   [2];
  bit         m_locked  [2];
  logic [8:0] m_par     [2];
  bit         m_val     [2];
  int         k;
  logic [1:0] hist[$];

  task automatic model_reset();
    k = 0;
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_anchor[i] = -1;
      m_count[i]  = 0;
      m_locked[i] = 1'b0;
      m_par[i]    = '0;
      m_val[i]    = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [1:0] d);
    logic [7:0] w;
    k++;
    hist.push_back(d);
    if (hist.size() > 4) void'(hist.pop_front());
    w = 8'h00;
    foreach (hist[j]) w = {w[5:0], hist[j]};
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 1'b0;
      if (m_locked[i]) begin
        if ((k - m_anchor[i]) % 4 == 0) begin
          m_par[i] = (w == 8'hBC) ? 9'h0BC : {1'b1, w};
          m_val[i] = 1'b1;
        end
      end else if (m_anchor[i] < 0) begin
        if (w == 8'hBC) begin
          m_anchor[i] = k;
          m_count[i]  = 1;
          if (lock_need[i] == 1) m_locked[i] = 1'b1;
        end
      end else if ((k - m_anchor[i]) % 4 == 0) begin
        if (w == 8'hBC) begin
          m_count[i]++;
          if (m_count[i] == lock_need[i]) m_locked[i] = 1'b1;
        end else begin
          m_anchor[i] = -1;
          m_count[i]  = 0;
        end
      end
    end
  endtask

  task automatic compare_model();
    check("model_par_L4", par0, m_par[0]);
    check("model_vld_L4", v0,   m_val[0]);
    check("model_act_L4", a0,   m_locked[0]);
    check("model_par_L1", par1, m_par[1]);
    check("model_vld_L1", v1,   m_val[1]);
    check("model_act_L1", a1,   m_locked[1]);
  endtask

  // ---------------- stimulus helpers ----------------
  logic [1:0] idle_d [4] = '{2'b10, 2'b11, 2'b11, 2'b00};

  task automatic step(input logic [1:0] d);
    @(negedge clk16f);
    serial = d;
    @(posedge clk16f);
    model_edge(d);
    #1;
    compare_model();
  endtask

  task automatic send_byte(input logic [7:0] b);
    step(b[7:6]);
    step(b[5:4]);
    step(b[3:2]);
    step(b[1:0]);
  endtask

  task automatic send_idle(input int n);
    for (int s = 0; s < n; s++) send_byte(8'hBC);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_par"},  par0, 9'h000);
    check({name, "_vld"},  v0,   1'b0);
    check({name, "_act"},  a0,   1'b0);
    check({name, "_act1"}, a1,   1'b0);
  endtask

  // Called just after a rising edge: asserts reset between edges, checks the async clear, releases later.
  task automatic do_reset(input string name);
    #2 reset_L = 1'b0;
    #1 check_cleared({name, "_async"});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk16f);
      serial = 2'($urandom);
      @(posedge clk16f);
      #1 check_cleared({name, "_hold"});
    end
    #1 reset_L = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [1:0] din;
    logic [8:0] par;
    logic       vld;
    logic       act;
  } vec_t;

  vec_t tbl [24];

  initial begin
    // Idle stream from the first edge after reset: lock on edge 16, first idle strobe on edge 20.
    for (int e = 1; e <= 24; e++) begin
      tbl[e-1].din = idle_d[(e-1) % 4];
      tbl[e-1].act = (e >= 16);
      tbl[e-1].vld = (e >= 20) && (e % 4 == 0);
      tbl[e-1].par = (e >= 20) ? 9'h0BC : 9'h000;
    end

    // 1. reset held while serial toggles
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk16f);
      serial = 2'($urandom);
      @(posedge clk16f);
      #1 check_cleared("reset_hold");
    end
    #1 reset_L = 1'b1;

    // 2 + 7. table-driven idle lock; lock-count-1 build locks on the first comma window
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].din);
      check("tbl_par", par0, tbl[i].par);
      check("tbl_vld", v0,   tbl[i].vld);
      check("tbl_act", a0,   tbl[i].act);
      if (i == 2) check("lock1_pre_act", a1, 1'b0);
      if (i == 3) check("lock1_act", a1, 1'b1);
      if (i == 7) check("lock1_first_word", {v1, par1}, {1'b1, 9'h0BC});
    end

    // 4. data symbol 0xA5 then idle
    send_byte(8'hA5);
    check("a5_word", {v0, par0}, {1'b1, 9'h1A5});
    step(idle_d[0]);
    check("a5_hold", {v0, par0}, {1'b0, 9'h1A5});
    step(idle_d[1]);
    step(idle_d[2]);
    step(idle_d[3]);
    check("a5_next_idle", {v0, par0}, {1'b1, 9'h0BC});

    // 3. one leading 00 dibit shifts everything by one edge: lock on edge 17
    do_reset("rst3");
    step(2'b00);
    for (int s = 0; s < 5; s++) begin
      for (int j = 0; j < 4; j++) begin
        step(idle_d[j]);
        if (k == 16) check("shift_pre_lock", a0, 1'b0);
        if (k == 17) check("shift_lock", a0, 1'b1);
      end
    end
    check("shift_first_word", {v0, par0}, {1'b1, 9'h0BC});

    // 5. non-comma symbol after two aligned commas returns to hunting
    do_reset("rst5");
    send_idle(2);
    send_byte(8'h3C);
    check("align_abort_act", a0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 4; j++) begin
        step(idle_d[j]);
        if (k == 27) check("realign_pre_lock", a0, 1'b0);
        if (k == 28) check("realign_lock", a0, 1'b1);
      end
    end
    send_idle(1);
    check("realign_word", {v0, par0}, {1'b1, 9'h0BC});

    // 6. reset during dibit 2 of a data symbol
    step(2'b01);
    step(2'b01);
    do_reset("rst6");
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 4; j++) begin
        step(idle_d[j]);
        if (k < 16) check("relock_no_strobe", v0, 1'b0);
        if (k == 15) check("relock_pre", a0, 1'b0);
        if (k == 16) check("relock", a0, 1'b1);
      end
    end

    // randomized: noise while hunting, then locked traffic mixing data and idle
    do_reset("rst_rnd_a");
    for (int n = 0; n < 40; n++) step(2'($urandom));
    do_reset("rst_rnd_b");
    send_idle(4);
    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      b = ($urandom_range(3) == 0) ? 8'hBC : 8'($urandom_range(255));
      if (b == 8'hBC && $urandom_range(1) == 0) b = 8'h00;
      send_byte(b);
      check("rnd_word", {v0, par0}, {1'b1, (b == 8'hBC) ? 9'h0BC : {1'b1, b}});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
